// File: rtl/fault_supervisor.sv
// fault_supervisor: owns the HV supply enable and gates transmit pulses.
// Runs a power-up hold (INIT), normal operation (RUN), a post-fault lockout
// (FAULT) and a host-cleared lock (LOCKED). Fault flags are sticky.
// Build option: define FAULT_SUPERVISOR_AUTO_RETRY_EN to let lockout expiry
// return to INIT up to MAX_RETRY times before locking.
//
// Strobe semantics: pulse_req_i and clear_req_i are single-cycle strobes with
// no backpressure; a strobe is consumed in the cycle it is high or discarded.
// The FSM state is always visible on sup_state_o.
module fault_supervisor #(
  parameter int unsigned    CW          = 24,
  parameter logic [CW-1:0]  INIT_CYC    = 24'd100000,
  parameter logic [CW-1:0]  LOCKOUT_CYC = 24'd1000000,
  parameter logic [1:0]     MAX_RETRY   = 2'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       protect_en,
  input  logic       SensorOK_en,
  input  logic       pulse_req,
  input  logic       clear_req,
  output logic       hv_enable,
  output logic       pulse_en,
  output logic [1:0] fault_flags,
  output logic [1:0] retry_cnt,
  output logic [1:0] sup_state
);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FAULT  = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  // Retry budget: zero when automatic retry is not built in, so lockout
  // expiry always lands in LOCKED and the retry counter never moves.
`ifdef FAULT_SUPERVISOR_AUTO_RETRY_EN
  localparam logic [1:0] RETRY_LIMIT = MAX_RETRY;
`else
  localparam logic [1:0] RETRY_LIMIT = MAX_RETRY & 2'b00;
`endif

  localparam logic [CW-1:0] INIT_LAST    = INIT_CYC - CW'(1);
  localparam logic [CW-1:0] LOCKOUT_LAST = LOCKOUT_CYC - CW'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] timer_q, timer_d;
  logic          hv_q, hv_d;
  logic          pulse_q, pulse_d;
  logic [1:0]    flags_q, flags_d;
  logic [1:0]    retry_q, retry_d;

  logic          fault;
  logic [CW-1:0] timer_inc;

  // Next-state, timer, flag and retry logic for the supervisor FSM.
  always_comb begin
    fault     = protect_en | ~SensorOK_en;
    timer_inc = (&timer_q) ? timer_q : timer_q + CW'(1);
    state_d   = state_q;
    timer_d   = timer_q;
    retry_d   = retry_q;
    pulse_d   = 1'b0;
    // Sticky flags; an active fault input always wins over a clear.
    flags_d   = flags_q | {~SensorOK_en, protect_en};

    unique case (state_q)
      ST_INIT: begin
        if (fault) begin
          timer_d = '0;
        end else if (timer_q == INIT_LAST) begin
          timer_d = '0;
          state_d = ST_RUN;
        end else begin
          timer_d = timer_inc;
        end
        if (clear_req && !fault) flags_d = 2'b00;
      end
      ST_RUN: begin
        if (fault) begin
          // A pulse request in the fault cycle is dropped.
          timer_d = '0;
          state_d = ST_FAULT;
        end else begin
          pulse_d = pulse_req;
          if (clear_req) flags_d = 2'b00;
        end
      end
      ST_FAULT: begin
        // Lockout is measured from fault release; clear_req is ignored.
        if (fault) begin
          timer_d = '0;
        end else if (timer_q == LOCKOUT_LAST) begin
          timer_d = '0;
          if (retry_q < RETRY_LIMIT) begin
            retry_d = retry_q + 2'd1;
            state_d = ST_INIT;
          end else begin
            state_d = ST_LOCKED;
          end
        end else begin
          timer_d = timer_inc;
        end
      end
      ST_LOCKED: begin
        if (clear_req && !fault) begin
          flags_d = 2'b00;
          retry_d = 2'b00;
          timer_d = '0;
          state_d = ST_INIT;
        end
      end
      default: state_d = ST_INIT;
    endcase

    // HV is on exactly while the registered state is RUN.
    hv_d = (state_d == ST_RUN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      timer_q <= '0;
      hv_q    <= 1'b0;
      pulse_q <= 1'b0;
      flags_q <= 2'b00;
      retry_q <= 2'b00;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      hv_q    <= hv_d;
      pulse_q <= pulse_d;
      flags_q <= flags_d;
      retry_q <= retry_d;
    end
  end

  assign hv_enable   = hv_q;
  assign pulse_en    = pulse_q;
  assign fault_flags = flags_q;
  assign retry_cnt   = retry_q;
  assign sup_state   = state_q;

endmodule

// File: tb/tb_fault_supervisor.sv
// Directed bench for fault_supervisor with INIT_CYC=10, LOCKOUT_CYC=20,
// MAX_RETRY=2. Follows the auto-retry path when
// FAULT_SUPERVISOR_AUTO_RETRY_EN is defined, the locking path otherwise.
module tb_fault_supervisor;

  logic       clk = 1'b0;
  logic       reset;
  logic       protect_en;
  logic       SensorOK_en;
  logic       pulse_req;
  logic       clear_req;
  logic       hv_enable;
  logic       pulse_en;
  logic [1:0] fault_flags;
  logic [1:0] retry_cnt;
  logic [1:0] sup_state;

  int n_checks = 0;
  int n_fail   = 0;

  fault_supervisor #(
    .CW(24),
    .INIT_CYC(24'd10),
    .LOCKOUT_CYC(24'd20),
    .MAX_RETRY(2'd2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .protect_en(protect_en),
    .SensorOK_en(SensorOK_en),
    .pulse_req(pulse_req),
    .clear_req(clear_req),
    .hv_enable(hv_enable),
    .pulse_en(pulse_en),
    .fault_flags(fault_flags),
    .retry_cnt(retry_cnt),
    .sup_state(sup_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, 32'(sup_state), 32'd0);
    check({tag, "_hv"},    32'(hv_enable), 32'd0);
    check({tag, "_pulse"}, 32'(pulse_en), 32'd0);
    check({tag, "_flags"}, 32'(fault_flags), 32'd0);
    check({tag, "_retry"}, 32'(retry_cnt), 32'd0);
  endtask

  // Run one protect fault from RUN (5 cycles high) through the 20-cycle lockout.
  task automatic protect_fault_lockout(input string tag);
    protect_en = 1'b1;
    tick(1);
    check({tag, "_state_fault"}, 32'(sup_state), 32'd2);
    check({tag, "_hv_off"},      32'(hv_enable), 32'd0);
    check({tag, "_flags"},       32'(fault_flags), 32'd1);
    tick(4);
    protect_en = 1'b0;
    tick(19);
    check({tag, "_still_fault"}, 32'(sup_state), 32'd2);
    tick(1);
  endtask

  initial begin
    reset = 1'b1; protect_en = 1'b0; SensorOK_en = 1'b1;
    pulse_req = 1'b0; clear_req = 1'b0;
    tick(2);
    check_reset_vals("reset");

    // Power-up hold: 10 fault-free cycles, then RUN with HV on.
    reset = 1'b0;
    tick(9);
    check("init_state_9", 32'(sup_state), 32'd0);
    check("init_hv_9",    32'(hv_enable), 32'd0);
    tick(1);
    check("run_state", 32'(sup_state), 32'd1);
    check("run_hv",    32'(hv_enable), 32'd1);

    // Pulse passes with one cycle of latency, one cycle wide.
    pulse_req = 1'b1;
    tick(1);
    pulse_req = 1'b0;
    check("pulse_n1", 32'(pulse_en), 32'd1);
    tick(1);
    check("pulse_n2", 32'(pulse_en), 32'd0);

    protect_fault_lockout("f1");
`ifdef FAULT_SUPERVISOR_AUTO_RETRY_EN
    check("f1_retry_state", 32'(sup_state), 32'd0);
    check("f1_retry_cnt",   32'(retry_cnt), 32'd1);
    tick(10);
    check("f1_rerun", 32'(sup_state), 32'd1);
    protect_fault_lockout("f2");
    check("f2_retry_state", 32'(sup_state), 32'd0);
    check("f2_retry_cnt",   32'(retry_cnt), 32'd2);
    tick(10);
    check("f2_rerun", 32'(sup_state), 32'd1);
    protect_fault_lockout("f3");
    check("f3_locked",    32'(sup_state), 32'd3);
    check("f3_retry_cnt", 32'(retry_cnt), 32'd2);
`else
    check("f1_locked",    32'(sup_state), 32'd3);
    check("f1_retry_cnt", 32'(retry_cnt), 32'd0);
`endif
    check("locked_hv", 32'(hv_enable), 32'd0);

    // Clear during an active protect fault is ignored.
    protect_en = 1'b1; clear_req = 1'b1;
    tick(1);
    protect_en = 1'b0; clear_req = 1'b0;
    check("clr_prot_state", 32'(sup_state), 32'd3);
    check("clr_prot_flags", 32'(fault_flags), 32'd1);

    // Clear during sensor fault: ignored, and the sensor flag sets.
    SensorOK_en = 1'b0; clear_req = 1'b1;
    tick(1);
    SensorOK_en = 1'b1; clear_req = 1'b0;
    check("clr_sens_state", 32'(sup_state), 32'd3);
    check("clr_sens_flags", 32'(fault_flags), 32'd3);

    // Clean clear leaves LOCKED for INIT with everything cleared.
    clear_req = 1'b1;
    tick(1);
    clear_req = 1'b0;
    check("clr_ok_state", 32'(sup_state), 32'd0);
    check("clr_ok_flags", 32'(fault_flags), 32'd0);
    check("clr_ok_retry", 32'(retry_cnt), 32'd0);
    check("clr_ok_hv",    32'(hv_enable), 32'd0);
    tick(10);
    check("rerun_state", 32'(sup_state), 32'd1);
    check("rerun_hv",    32'(hv_enable), 32'd1);

    // Sensor loss coincident with pulse and clear: pulse dropped, flag set.
    SensorOK_en = 1'b0; pulse_req = 1'b1; clear_req = 1'b1;
    tick(1);
    SensorOK_en = 1'b1; pulse_req = 1'b0; clear_req = 1'b0;
    check("sens_pulse", 32'(pulse_en), 32'd0);
    check("sens_flags", 32'(fault_flags), 32'd2);
    check("sens_state", 32'(sup_state), 32'd2);
    check("sens_hv",    32'(hv_enable), 32'd0);
    tick(5);
    check("sens_mid_lockout", 32'(sup_state), 32'd2);

    // Reset mid-lockout returns everything to reset values.
    reset = 1'b1;
    tick(1);
    check_reset_vals("midreset");

    // Pulse request in INIT is discarded.
    reset = 1'b0; pulse_req = 1'b1;
    tick(1);
    pulse_req = 1'b0;
    check("init_pulse_drop", 32'(pulse_en), 32'd0);
    tick(4);

    // A fault in INIT restarts the hold count from zero.
    protect_en = 1'b1;
    tick(1);
    protect_en = 1'b0;
    check("init_fault_state", 32'(sup_state), 32'd0);
    check("init_fault_flags", 32'(fault_flags), 32'd1);
    tick(9);
    check("init_restart_9", 32'(sup_state), 32'd0);
    tick(1);
    check("init_restart_run", 32'(sup_state), 32'd1);

    // Clean clear in RUN drops the flags and keeps running.
    clear_req = 1'b1;
    tick(1);
    clear_req = 1'b0;
    check("run_clr_flags", 32'(fault_flags), 32'd0);
    check("run_clr_state", 32'(sup_state), 32'd1);
    check("run_clr_hv",    32'(hv_enable), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
